// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module : arith_pkg
// Shared widths, constants and result record for the 8-bit arithmetic unit.
// Rev    : 1.0
// ============================================================================
package arith_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 16;
  localparam logic [DATA_W-1:0] DIV0_QUOT = 8'hFF;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic              dbz;
  } arith_res_t;

endpackage
`default_nettype wire

// File: rtl/arith_div8.sv
`default_nettype none
// ============================================================================
// Module : arith_div8
// Combinational 8-step restoring divider; b==0 yields quot=FF, rem=dividend.
// Rev    : 1.0
// ============================================================================
module arith_div8
  import arith_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              dbz
);

  logic [DATA_W-1:0] w_part;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_quot;

  // The running remainder is always < divisor, so it fits in DATA_W bits.
  always_comb begin
    w_part  = '0;
    w_trial = '0;
    w_quot  = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w_trial = {w_part, dividend[i]};
      if (w_trial >= {1'b0, divisor}) begin
        w_part    = DATA_W'(w_trial - {1'b0, divisor});
        w_quot[i] = 1'b1;
      end else begin
        w_part = w_trial[DATA_W-1:0];
      end
    end
  end

  assign dbz  = (divisor == '0);
  assign quot = dbz ? DIV0_QUOT : w_quot;
  assign rem  = dbz ? dividend  : w_part;

endmodule
`default_nettype wire

// File: rtl/arithmetic_top.sv
`default_nettype none
// ============================================================================
// Module : arithmetic_top
// Two-stage unsigned 8-bit add/sub/mul/div unit: operand register, result register.
// Rev    : 1.0
// ============================================================================
module arithmetic_top
  import arith_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [DATA_W-1:0] sum,
  output logic [PROD_W-1:0] prod,
  output logic [DATA_W-1:0] diff,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_v1;
  logic              r_out_valid;
  arith_res_t        r_res;

  logic [DATA_W-1:0] w_quot;
  logic [DATA_W-1:0] w_rem;
  logic              w_dbz;

  arith_div8 u_div (
    .dividend (r_a),
    .divisor  (r_b),
    .quot     (w_quot),
    .rem      (w_rem),
    .dbz      (w_dbz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a <= a;
        r_b <= b;
      end
    end
  end

  // Results only update on a valid stage-1 slot, so they hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_res.sum  <= r_a + r_b;
        r_res.diff <= r_a - r_b;
        r_res.prod <= PROD_W'(r_a) * PROD_W'(r_b);
        r_res.quot <= w_quot;
        r_res.rem  <= w_rem;
        r_res.dbz  <= w_dbz;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign sum         = r_res.sum;
  assign prod        = r_res.prod;
  assign diff        = r_res.diff;
  assign quotient    = r_res.quot;
  assign remainder   = r_res.rem;
  assign div_by_zero = r_res.dbz;

endmodule
`default_nettype wire

// File: tb/tb_arithmetic_top.sv
`default_nettype none
// ============================================================================
// Module : tb_arithmetic_top
// Table vectors, reset corner case and random sweep, scored through a due-cycle queue.
// Rev    : 1.0
// ============================================================================
module tb_arithmetic_top;

  typedef struct packed {
    logic [7:0]  sum;
    logic [15:0] prod;
    logic [7:0]  diff;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  typedef struct {
    int   due;
    exp_t e;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [7:0]  sum;
  logic [15:0] prod;
  logic [7:0]  diff;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t last = '0;
  sb_t  sbq[$];

  always #5 clk = ~clk;

  arithmetic_top dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .sum         (sum),
    .prod        (prod),
    .diff        (diff),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.sum  = x + y;
    e.diff = x - y;
    e.prod = 16'(x) * 16'(y);
    if (y == 8'd0) begin
      e.q   = 8'hFF;
      e.r   = x;
      e.dbz = 1'b1;
    end else begin
      e.q   = x / y;
      e.r   = x % y;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic ev);
    exp_t g;
    g = {sum, prod, diff, quotient, remainder, div_by_zero};
    n_checks++;
    if (g !== e || out_valid !== ev) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got v=%0b sum=%0d prod=%0d diff=%0d q=%0d r=%0d dbz=%0b required v=%0b sum=%0d prod=%0d diff=%0d q=%0d r=%0d dbz=%0b",
               nm, cyc, out_valid, g.sum, g.prod, g.diff, g.q, g.r, g.dbz,
               ev, e.sum, e.prod, e.diff, e.q, e.r, e.dbz);
    end
  endtask

  task automatic check_cycle();
    sb_t s;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      s = sbq.pop_front();
      cmp("result", s.e, 1'b1);
      last = s.e;
    end else begin
      cmp("hold", last, 1'b0);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib, input exp_t e);
    in_valid = v;
    a        = ia;
    b        = ib;
    if (v) sbq.push_back('{due: cyc + 2, e: e});
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  vec_t tbl[8];

  initial begin
    logic [7:0] ra, rb;
    logic       rv;

    tbl[0] = '{8'd20,  8'd10,  '{8'd30,  16'd200,   8'd10,  8'd2,   8'd0,   1'b0}};
    tbl[1] = '{8'd50,  8'd20,  '{8'd70,  16'd1000,  8'd30,  8'd2,   8'd10,  1'b0}};
    tbl[2] = '{8'd15,  8'd4,   '{8'd19,  16'd60,    8'd11,  8'd3,   8'd3,   1'b0}};
    tbl[3] = '{8'd0,   8'd7,   '{8'd7,   16'd0,     8'd249, 8'd0,   8'd0,   1'b0}};
    tbl[4] = '{8'd255, 8'd255, '{8'd254, 16'd65025, 8'd0,   8'd1,   8'd0,   1'b0}};
    tbl[5] = '{8'd200, 8'd0,   '{8'd200, 16'd0,     8'd200, 8'd255, 8'd200, 1'b1}};
    tbl[6] = '{8'd255, 8'd1,   '{8'd0,   16'd255,   8'd254, 8'd255, 8'd0,   1'b0}};
    tbl[7] = '{8'd7,   8'd9,   '{8'd16,  16'd63,    8'd254, 8'd0,   8'd7,   1'b0}};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", '0, 1'b0);
    #3 rst_n = 1'b1;

    // Table vectors back-to-back, then a gap where results must hold.
    for (int i = 0; i < 8; i++) step(1'b1, tbl[i].a, tbl[i].b, tbl[i].e);
    repeat (4) step(1'b0, 8'd0, 8'd0, '0);

    // Isolated op to confirm exact two-edge latency after an idle period.
    step(1'b1, 8'd20, 8'd10, tbl[0].e);
    repeat (3) step(1'b0, 8'd99, 8'd3, '0);

    // Async reset with two operations in flight.
    step(1'b1, 8'd100, 8'd3, model(8'd100, 8'd3));
    step(1'b1, 8'd9,   8'd0, model(8'd9, 8'd0));
    in_valid = 1'b1;
    a        = 8'd77;
    b        = 8'd5;
    #2 rst_n = 1'b0;
    #1;
    cmp("reset_async", '0, 1'b0);
    sbq.delete();
    last     = '0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    cmp("reset_held", '0, 1'b0);
    #2 rst_n = 1'b1;
    repeat (3) step(1'b0, 8'd0, 8'd0, '0);
    step(1'b1, 8'd33, 8'd8, model(8'd33, 8'd8));
    repeat (3) step(1'b0, 8'd0, 8'd0, '0);

    // Random sweep with occasional bubbles, a forced gap and frequent b==0.
    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 19) != 0) && !(i >= 5000 && i < 5006);
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      step(rv, ra, rb, model(ra, rb));
    end
    repeat (4) step(1'b0, 8'd0, 8'd0, '0);

    n_checks++;
    if (sbq.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending results required 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
